cnm_mac: RTL and testbench

CNM_MAC -- requirements
Module: cnm_mac

---
 rtl/cnm_mac.sv | 250 +++++++++++++++++++++++++
 tb/tb_cnm_mac.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnm_mac.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cnm_mac -- sequential complex multiply-accumulate, fixed point
//
// Computes A*Q (A = rea + j*ima, Q = req + j*imq) with one shared signed
// WIDTHxWIDTH multiplier, one partial product per state. The products are
// either loaded into, or added to, a pair of wide accumulators that hold
// their value between transfers. The accumulators are then rounded, shifted
// back to the operand Q format and reduced to WIDTH bits.
//
// Parameters
//   WIDTH  operand/result width (>= 4)
//   FRAC   fractional bits of operands and results (1..WIDTH-1)
//   GUARD  accumulator guard bits, AW = 2*WIDTH + 1 + GUARD
//
// Ports
//   clk, nreset            clock, asynchronous active-low reset
//   in_valid / in_ready    operand handshake
//   rea, ima, req, imq     operands (signed, WIDTH)
//   acc_mode               0 = load product, 1 = add product to accumulator
//   out_valid / out_ready  result handshake
//   rep, imp               real/imag result (signed, WIDTH)
//   ovf                    result of this transfer was saturated
//   state_o                current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only while idle; out_valid is high only
// while a result is held, and the result is stable until it is taken.
//
// Build option
//   CNM_MAC_SAT_EN  defined: out-of-range results clamp and raise ovf.
//                   undefined: results wrap to WIDTH bits, ovf stays 0.
// -----------------------------------------------------------------------------
module cnm_mac #(
    parameter int WIDTH = 8,
    parameter int FRAC  = WIDTH - 1,
    parameter int GUARD = 4
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] rea,
    input  logic signed [WIDTH-1:0] ima,
    input  logic signed [WIDTH-1:0] req,
    input  logic signed [WIDTH-1:0] imq,
    input  logic                    acc_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] rep,
    output logic signed [WIDTH-1:0] imp,
    output logic                    ovf,
    output logic [2:0]              state_o
);

    localparam int AW = 2 * WIDTH + 1 + GUARD;
    localparam int PW = 2 * WIDTH;

    // Rounding constant, half an LSB of the result, at AW+1 bits so the
    // rounding add itself can never wrap.
    localparam logic signed [AW:0] RND_INC = (AW + 1)'(1) << (FRAC - 1);

`ifdef CNM_MAC_SAT_EN
    localparam logic signed [AW:0] SAT_MAX = (AW + 1)'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [AW:0] SAT_MIN = -((AW + 1)'(2 ** (WIDTH - 1)));
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M0   = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        M3   = 3'd4,
        RND  = 3'd5,
        OUT  = 3'd6
    } state_t;

    state_t state_q, state_d;

    logic signed [WIDTH-1:0] rea_q, rea_d;
    logic signed [WIDTH-1:0] ima_q, ima_d;
    logic signed [WIDTH-1:0] req_q, req_d;
    logic signed [WIDTH-1:0] imq_q, imq_d;
    logic                    mode_q, mode_d;

    logic signed [AW-1:0]    acc_re_q, acc_re_d;
    logic signed [AW-1:0]    acc_im_q, acc_im_d;

    logic signed [WIDTH-1:0] rep_q, rep_d;
    logic signed [WIDTH-1:0] imp_q, imp_d;
    logic                    ovf_q, ovf_d;

    logic signed [WIDTH-1:0] mul_a;
    logic signed [WIDTH-1:0] mul_b;
    logic signed [PW-1:0]    prod;
    logic signed [AW-1:0]    prod_ext;

    logic [WIDTH:0]          red_re;
    logic [WIDTH:0]          red_im;

    // Round half up, arithmetic shift by FRAC, reduce to WIDTH bits.
    // Returns {ovf, result}.
    function automatic logic [WIDTH:0] reduce(input logic signed [AW-1:0] acc);
        logic signed [AW:0] ext;
        logic signed [AW:0] sum;
        logic signed [AW:0] sh;
        logic [WIDTH:0]     res;
        ext = {acc[AW-1], acc};
        sum = ext + RND_INC;
        sh  = sum >>> FRAC;
`ifdef CNM_MAC_SAT_EN
        if (sh > SAT_MAX) begin
            res = {1'b1, SAT_MAX[WIDTH-1:0]};
        end else if (sh < SAT_MIN) begin
            res = {1'b1, SAT_MIN[WIDTH-1:0]};
        end else begin
            res = {1'b0, sh[WIDTH-1:0]};
        end
`else
        res = {1'b0, sh[WIDTH-1:0]};
`endif
        return res;
    endfunction

    // Shared multiplier: operand pair chosen by the current state.
    always_comb begin
        mul_a = rea_q;
        mul_b = req_q;
        case (state_q)
            M1: begin
                mul_a = ima_q;
                mul_b = imq_q;
            end
            M2: begin
                mul_a = rea_q;
                mul_b = imq_q;
            end
            M3: begin
                mul_a = ima_q;
                mul_b = req_q;
            end
            default: begin
                mul_a = rea_q;
                mul_b = req_q;
            end
        endcase
    end

    assign prod     = PW'(mul_a) * PW'(mul_b);
    assign prod_ext = {{(AW - PW){prod[PW-1]}}, prod};

    assign red_re = reduce(acc_re_q);
    assign red_im = reduce(acc_im_q);

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        rea_d     = rea_q;
        ima_d     = ima_q;
        req_d     = req_q;
        imq_d     = imq_q;
        mode_d    = mode_q;
        acc_re_d  = acc_re_q;
        acc_im_d  = acc_im_q;
        rep_d     = rep_q;
        imp_d     = imp_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    rea_d   = rea;
                    ima_d   = ima;
                    req_d   = req;
                    imq_d   = imq;
                    mode_d  = acc_mode;
                    state_d = M0;
                end
            end
            M0: begin
                acc_re_d = mode_q ? (acc_re_q + prod_ext) : prod_ext;
                state_d  = M1;
            end
            M1: begin
                acc_re_d = acc_re_q - prod_ext;
                state_d  = M2;
            end
            M2: begin
                acc_im_d = mode_q ? (acc_im_q + prod_ext) : prod_ext;
                state_d  = M3;
            end
            M3: begin
                acc_im_d = acc_im_q + prod_ext;
                state_d  = RND;
            end
            RND: begin
                rep_d   = red_re[WIDTH-1:0];
                imp_d   = red_im[WIDTH-1:0];
                ovf_d   = red_re[WIDTH] | red_im[WIDTH];
                state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= IDLE;
            rea_q    <= '0;
            ima_q    <= '0;
            req_q    <= '0;
            imq_q    <= '0;
            mode_q   <= 1'b0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            rep_q    <= '0;
            imp_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rea_q    <= rea_d;
            ima_q    <= ima_d;
            req_q    <= req_d;
            imq_q    <= imq_d;
            mode_q   <= mode_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            rep_q    <= rep_d;
            imp_q    <= imp_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rep     = rep_q;
    assign imp     = imp_q;
    assign ovf     = ovf_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_cnm_mac.sv
`timescale 1ns/1ps
module tb_cnm_mac;

    localparam int WIDTH = 8;
    localparam int FRAC  = 7;
    localparam int GUARD = 4;
    localparam int AW    = 2 * WIDTH + 1 + GUARD;

    // clock / reset
    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] rea, ima, req, imq;
    logic                    acc_mode;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] rep, imp;
    logic                    ovf;
    logic [2:0]              state_o;

    cnm_mac #(.WIDTH(WIDTH), .FRAC(FRAC), .GUARD(GUARD)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rea      (rea),
        .ima      (ima),
        .req      (req),
        .imq      (imq),
        .acc_mode (acc_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .rep      (rep),
        .imp      (imp),
        .ovf      (ovf),
        .state_o  (state_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: complex accumulator as plain integers
    longint m_acc_re = 0;
    longint m_acc_im = 0;

    // scoreboard
    logic [WIDTH-1:0] exp_re_q[$];
    logic [WIDTH-1:0] exp_im_q[$];
    logic             exp_ovf_q[$];

    logic signed [WIDTH-1:0] last_re, last_im;
    logic                    last_ovf;

    function automatic longint wrap_aw(input longint v);
        longint m;
        longint r;
        m = longint'(1) << AW;
        r = ((v % m) + m) % m;
        if (r >= (m >>> 1)) r = r - m;
        return r;
    endfunction

    // value = acc / 2^FRAC rounded half up, then clamped or wrapped to WIDTH
    function automatic void model_reduce(input longint acc, output logic [WIDTH-1:0] r,
                                         output logic o);
        longint s;
        longint lo;
        longint hi;
        s  = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
        hi = (longint'(1) << (WIDTH - 1)) - 1;
        lo = -(longint'(1) << (WIDTH - 1));
`ifdef CNM_MAC_SAT_EN
        if (s > hi) begin
            r = hi[WIDTH-1:0];
            o = 1'b1;
        end else if (s < lo) begin
            r = lo[WIDTH-1:0];
            o = 1'b1;
        end else begin
            r = s[WIDTH-1:0];
            o = 1'b0;
        end
`else
        r = s[WIDTH-1:0];
        o = 1'b0;
`endif
    endfunction

    task automatic model_accept(input logic signed [WIDTH-1:0] ar, ai, qr, qi,
                                input logic mode);
        longint pre, pim;
        logic [WIDTH-1:0] r, i;
        logic o_re, o_im;
        pre = longint'(ar) * longint'(qr) - longint'(ai) * longint'(qi);
        pim = longint'(ar) * longint'(qi) + longint'(ai) * longint'(qr);
        m_acc_re = wrap_aw((mode ? m_acc_re : 0) + pre);
        m_acc_im = wrap_aw((mode ? m_acc_im : 0) + pim);
        model_reduce(m_acc_re, r, o_re);
        model_reduce(m_acc_im, i, o_im);
        exp_re_q.push_back(r);
        exp_im_q.push_back(i);
        exp_ovf_q.push_back(o_re | o_im);
    endtask

    task automatic scramble_inputs();
        rea      = WIDTH'($urandom);
        ima      = WIDTH'($urandom);
        req      = WIDTH'($urandom);
        imq      = WIDTH'($urandom);
        acc_mode = 1'($urandom_range(0, 1));
    endtask

    // driver: one full transaction, result held 'hold' cycles before taken
    task automatic run_op(input logic signed [WIDTH-1:0] ar, ai, qr, qi,
                          input logic mode, input int hold);
        int waitc;
        int lat;
        logic [WIDTH-1:0] er, ei;
        logic eo;
        logic signed [WIDTH-1:0] cap_re, cap_im;
        logic cap_ovf;

        @(negedge clk);
        rea = ar; ima = ai; req = qr; imq = qi; acc_mode = mode;
        in_valid = 1'b1;
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(ar, ai, qr, qi, mode);
        #1;
        in_valid = 1'b0;
        scramble_inputs();

        // the accepting edge counts as edge 1; out_valid must follow edge 6
        lat = 1;
        while (out_valid !== 1'b1 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            in_valid = 1'($urandom_range(0, 1));
            scramble_inputs();
        end
        n_checks++;
        if (lat !== 6) begin
            n_fail++;
            $display("FAIL latency: got %0d edges, required 6", lat);
        end

        er = exp_re_q.pop_front();
        ei = exp_im_q.pop_front();
        eo = exp_ovf_q.pop_front();
        n_checks++;
        if (rep !== er) begin
            n_fail++;
            $display("FAIL rep: got %0d required %0d", rep, $signed(er));
        end
        n_checks++;
        if (imp !== ei) begin
            n_fail++;
            $display("FAIL imp: got %0d required %0d", imp, $signed(ei));
        end
        n_checks++;
        if (ovf !== eo) begin
            n_fail++;
            $display("FAIL ovf: got %b required %b", ovf, eo);
        end
        cap_re = rep; cap_im = imp; cap_ovf = ovf;
        last_re = rep; last_im = imp; last_ovf = ovf;

        // result held: outputs frozen, inputs ignored
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || rep !== cap_re ||
                imp !== cap_im || ovf !== cap_ovf) begin
                n_fail++;
                $display("FAIL hold_stable: ov=%b ir=%b rep=%0d imp=%0d ovf=%b required ov=1 ir=0 rep=%0d imp=%0d ovf=%b",
                         out_valid, in_ready, rep, imp, ovf, cap_re, cap_im, cap_ovf);
            end
            in_valid = ~in_valid;
            scramble_inputs();
        end

        // take the result; in_valid high on this edge must not be accepted
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        nreset    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rea = '0; ima = '0; req = '0; imq = '0; acc_mode = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || rep !== 8'sd0 || imp !== 8'sd0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ov=%b rep=%0d imp=%0d ovf=%b required all 0",
                     out_valid, rep, imp, ovf);
        end
        nreset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        m_acc_re = 0;
        m_acc_im = 0;
    endtask

    task automatic test_directed();
        run_op(8'sd64, 8'sd0, 8'sd64, 8'sd0, 1'b0, 0);
        n_checks++;
        if (last_re !== 8'sd32 || last_im !== 8'sd0 || last_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL half_squared: got %0d/%0d/%b required 32/0/0", last_re, last_im, last_ovf);
        end
        run_op(8'sd64, 8'sd64, 8'sd64, 8'sd64, 1'b0, 1);
        n_checks++;
        if (last_re !== 8'sd0 || last_im !== 8'sd64) begin
            n_fail++;
            $display("FAIL complex_square: got %0d/%0d required 0/64", last_re, last_im);
        end
        run_op(-8'sd128, 8'sd0, -8'sd128, 8'sd0, 1'b0, 0);
        n_checks++;
`ifdef CNM_MAC_SAT_EN
        if (last_re !== 8'sd127 || last_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL full_scale: got %0d/%b required 127/1", last_re, last_ovf);
        end
`else
        if (last_re !== -8'sd128 || last_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL full_scale: got %0d/%b required -128/0", last_re, last_ovf);
        end
`endif
        run_op(8'sd64, 8'sd0, 8'sd64, 8'sd0, 1'b0, 0);
        run_op(8'sd64, 8'sd0, 8'sd64, 8'sd0, 1'b1, 3);
        n_checks++;
        if (last_re !== 8'sd64 || last_im !== 8'sd0) begin
            n_fail++;
            $display("FAIL accumulate: got %0d/%0d required 64/0", last_re, last_im);
        end
    endtask

    task automatic test_reset_abort();
        int waitc;
        int seen;
        @(negedge clk);
        rea = 8'sd100; ima = -8'sd50; req = 8'sd30; imq = 8'sd70; acc_mode = 1'b1;
        in_valid = 1'b1;
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        @(posedge clk);     // accepted, now in M0
        #1 in_valid = 1'b0;
        @(posedge clk);     // M1
        @(posedge clk);     // M2
        #2 nreset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || rep !== 8'sd0 || imp !== 8'sd0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: ov=%b rep=%0d imp=%0d ovf=%b required all 0",
                     out_valid, rep, imp, ovf);
        end
        m_acc_re = 0;
        m_acc_im = 0;
        @(negedge clk);
        nreset = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_output: out_valid high %0d cycles required 0", seen);
        end
        run_op(8'sd64, 8'sd0, 8'sd64, 8'sd0, 1'b1, 0);
        n_checks++;
        if (last_re !== 8'sd32 || last_im !== 8'sd0) begin
            n_fail++;
            $display("FAIL after_abort: got %0d/%0d required 32/0", last_re, last_im);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
    endtask

    task automatic test_back_to_back();
        // accumulate full-scale products repeatedly, result taken immediately
        run_op(-8'sd128, -8'sd128, -8'sd128, 8'sd127, 1'b0, 0);
        for (int k = 0; k < 8; k++) begin
            run_op(-8'sd128, -8'sd128, -8'sd128, 8'sd127, 1'b1, 0);
        end
        for (int k = 0; k < 6; k++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                   1'b1, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
